shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit shift datapath. Supports SLL, SRA and ROR.
- Performs a log-barrel shift one stage per cycle: stage k applies a shift of 2^k when offset[k] is set.
- Uses a start/busy/done handshake so the execute stage can share one narrow stage shifter instead of a full combinational barrel.
- Sits beside the ALU. The pipeline stalls on busy.

Parameters:
- DATA_W, 16, datapath width in bits.
- SHAMT_W, 4, shift-amount width and number of stages. 2^SHAMT_W must equal DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when accepting (see Behaviour).
- opcode  input  3  000=SLL, 001=SRA, 010=ROR, others illegal.
- in  input  DATA_W  operand, captured at acceptance.
- offset  input  SHAMT_W  shift amount, captured at acceptance.
- busy  output  1  operation in progress; pipeline stall request.
- done  output  1  one-cycle pulse, result valid.
- err  output  1  one-cycle pulse coincident with done for an illegal opcode.
- out  output  DATA_W  result register, held until the next acceptance.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, err=0, out=0.
  - Internal operand, offset, opcode and stage counter all cleared.
- States: IDLE, SHIFT, DONE.
- Acceptance:
  - start=1 at a rising edge while state is IDLE or DONE.
  - Captures in, offset and opcode into internal registers; stage counter=0; state goes to SHIFT.
- start while in SHIFT: ignored. Nothing is queued and the operands are not recaptured.
- SHIFT: each rising edge processes stage k = counter (0..SHAMT_W-1).
  - If offset_r[k]=1, the working register shifts by 2^k per opcode:
    - SLL: zero-fill from the LSB.
    - SRA: replicate bit DATA_W-1.
    - ROR: bits leaving the LSB re-enter at the MSB.
  - If offset_r[k]=0, the working register holds.
  - Counter increments. After stage SHAMT_W-1, the final value loads into out and state goes to DONE.
- Fixed latency:
  - Acceptance at edge E gives busy=1 for the cycles following edges E..E+SHAMT_W-1.
  - done=1 for exactly the cycle following edge E+SHAMT_W.
  - Latency does not depend on offset; offset=0 still takes SHAMT_W cycles.
- DONE:
  - Lasts one cycle. busy=0 and done=1.
  - Returns to IDLE unless start=1, which triggers back-to-back acceptance (done then drops and busy rises).
- out:
  - Changes only on the edge entering DONE, or on reset.
  - Stable throughout IDLE and SHIFT.
- Illegal opcode (011..111):
  - Sequences with the same latency.
  - Working register is never modified, so out=captured in.
  - err=1 in the DONE cycle.
- Reset mid-operation: aborts immediately. All outputs take their reset values; no done is produced.
- busy, done and err are registered (state decode only); there is no combinational path from inputs to outputs.
- Arithmetic:
  - All shifts are within DATA_W bits; no widening.
  - SRA right shift of a negative value by DATA_W-1 yields all ones.

Test Plan:
- SLL, in=16'h0001, offset=15, start pulse from IDLE -> busy high 4 cycles, done pulse in cycle 5, out=16'h8000, err=0.
- SRA:
  - in=16'h8000, offset=4 -> out=16'hF800.
  - in=16'h7FFF, offset=15 -> out=16'h0000.
  - in=16'hFFFF, offset=15 -> out=16'hFFFF.
- ROR, in=16'h0001, offset=15 -> out=16'h0002.
  - ROR in=16'h1234, offset=4 -> out=16'h4123.
  - ROR in=16'hABCD, offset=0 -> out=16'hABCD, still 4 busy cycles.
- Handshake:
  - Assert start with new operands during SHIFT cycle 2 -> ignored, first result unaffected.
  - Assert start during the DONE cycle -> second op accepted, next done exactly 5 cycles later, first out held until then.
- opcode=3'b101, in=16'h5A5A, offset=3 -> done and err pulse together after 4 busy cycles, out=16'h5A5A.
- Reset:
  - Drop rst_n asynchronously mid-SHIFT (between edges) -> busy, done, err and out go to 0 immediately, no done after release.
  - After release, a fresh SLL in=16'h00FF, offset=8 -> out=16'hFF00.
- Randomized self-check: 4096 random in/offset per opcode against the reference expressions (in << offset; signed in >>> offset; lower DATA_W bits of {in,in} >> offset) -> zero mismatches.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle log-barrel shifter: one stage per cycle, SLL/SRA/ROR, start/busy/done handshake.
// A request is accepted from IDLE or DONE; latency is always SHAMT_W cycles of busy, then one done cycle.
module shift_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         opcode,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] offset,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  out
);
  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [SHAMT_W-1:0] off_q,   off_d;
  logic [2:0]         op_q,    op_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [DATA_W-1:0]  out_q,   out_d;

  logic                accept;
  logic                last_stage;
  logic [SHAMT_W-1:0]  amt;
  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   stage_val;

  assign accept     = start && (state_q != SHIFT);
  assign last_stage = (cnt_q == CNT_W'(SHAMT_W - 1));

  // Single narrow stage: shift by 2^cnt when the matching offset bit is set.
  always_comb begin
    amt       = SHAMT_W'(1) << cnt_q;
    dbl       = {data_q, data_q} >> amt;
    stage_val = data_q;
    if (off_q[cnt_q]) begin
      case (op_q)
        OP_SLL:  stage_val = data_q << amt;
        OP_SRA:  stage_val = $unsigned($signed(data_q) >>> amt);
        OP_ROR:  stage_val = dbl[DATA_W-1:0];
        default: stage_val = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      off_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      off_q   <= off_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_stage) state_d = DONE;
      DONE:    state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    off_d  = off_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (accept) begin
      data_d = in;
      off_d  = offset;
      op_d   = opcode;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      data_d = stage_val;
      cnt_d  = cnt_q + CNT_W'(1);
      if (last_stage) out_d = stage_val;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    err  = (state_q == DONE) && (op_q > OP_ROR);
    out  = out_q;
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and random checks for shift_seq_ctrl: latency, handshake, illegal opcode, async reset.
module tb_shift_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] din;
  logic [3:0]  offset;
  logic        busy, done, err;
  logic [15:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_out;

  shift_seq_ctrl #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .in(din),
    .offset(offset), .busy(busy), .done(done), .err(err), .out(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_f(input logic [2:0] op, input logic [15:0] d, input logic [3:0] o);
    logic signed [15:0] s;
    logic [31:0] t;
    s = d;
    t = {d, d} >> o;
    case (op)
      3'b000:  return d << o;
      3'b001:  return s >>> o;
      3'b010:  return t[15:0];
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after an edge; ends in the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] d, input logic [3:0] off,
                        input logic [15:0] exp, input logic exp_err, input string tag, input bit full);
    start = 1'b1; opcode = op; din = d; offset = off;
    step();
    start = 1'b0; din = ~d; offset = ~off; opcode = 3'b011;
    for (int i = 0; i < 4; i++) begin
      if (full) begin
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " done_lo"}, done, 1'b0);
        chk({tag, " out_held"}, dout, last_out);
      end
      step();
    end
    chk({tag, " out"}, dout, exp);
    chk({tag, " done"}, done, 1'b1);
    if (full) begin
      chk({tag, " busy_lo"}, busy, 1'b0);
      chk({tag, " err"}, err, exp_err);
    end
    last_out = exp;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 3'b000; din = 16'h0; offset = 4'h0;
    last_out = 16'h0;
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst out", dout, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op(3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0, "sll_1_15", 1); step();
    run_op(3'b001, 16'h8000, 4'd4,  16'hF800, 1'b0, "sra_8000_4", 1); step();
    run_op(3'b001, 16'h7FFF, 4'd15, 16'h0000, 1'b0, "sra_7fff_15", 1); step();
    run_op(3'b001, 16'hFFFF, 4'd15, 16'hFFFF, 1'b0, "sra_ffff_15", 1); step();
    run_op(3'b010, 16'h0001, 4'd15, 16'h0002, 1'b0, "ror_1_15", 1); step();
    run_op(3'b010, 16'h1234, 4'd4,  16'h4123, 1'b0, "ror_1234_4", 1); step();
    run_op(3'b010, 16'hABCD, 4'd0,  16'hABCD, 1'b0, "ror_abcd_0", 1); step();
    run_op(3'b101, 16'h5A5A, 4'd3,  16'h5A5A, 1'b1, "illegal", 1);
    step();
    chk("illegal err_lo", err, 1'b0);
    chk("illegal done_lo", done, 1'b0);

    // start during SHIFT must be ignored
    start = 1'b1; opcode = 3'b000; din = 16'h0001; offset = 4'd15;
    step();
    start = 1'b0; din = 16'hFFFF; offset = 4'd0; opcode = 3'b010;
    step();
    start = 1'b1; din = 16'h00F0; offset = 4'd3; opcode = 3'b001;
    step();
    start = 1'b0;
    chk("ign busy", busy, 1'b1);
    step();
    chk("ign busy2", busy, 1'b1);
    chk("ign out_held", dout, last_out);
    step();
    chk("ign done", done, 1'b1);
    chk("ign out", dout, 16'h8000);
    last_out = 16'h8000;

    // back-to-back acceptance from the DONE cycle
    run_op(3'b001, 16'h8000, 4'd4, 16'hF800, 1'b0, "b2b", 1);
    step();

    // async reset mid-SHIFT
    start = 1'b1; opcode = 3'b000; din = 16'h0003; offset = 4'd1;
    step();
    start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort err", err, 1'b0);
    chk("abort out", dout, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    last_out = 16'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst no_done", {busy, done}, 2'b00);
    end
    run_op(3'b000, 16'h00FF, 4'd8, 16'hFF00, 1'b0, "sll_after_rst", 1);
    step();

    for (int op = 0; op < 3; op++) begin
      for (int n = 0; n < 4096; n++) begin
        logic [15:0] d;
        logic [3:0]  o;
        d = 16'($urandom);
        o = 4'($urandom_range(0, 15));
        run_op(3'(op), d, o, ref_f(3'(op), d, o), 1'b0, "rand", 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
